mazesolver_soc_sysid_checker: RTL and testbench
===============================================

// Module: mazesolver_soc_sysid_checker
// PURPOSE
//  Boot-time consumer of the system-ID Avalon slave. After reset it waits a
//  settle period, reads word 0 (system ID) and word 1 (build timestamp), and
//  compares each against the expected values. It raises done plus per-field
//  ok flags, which gate the maze-solver start logic and feed a status LED.
//  A recheck pulse repeats the sequence without a reset.
// PARAMETERS
//  EXPECTED_ID     32'h0000_0000  value required at sysid word 0
//  EXPECTED_TS     32'h5657_0804  value required at sysid word 1 (1448544260)
//  CHECK_TS        1              1: ts_ok needs a match; 0: ts_ok forced 1 in CHECK
//  STARTUP_CYCLES  4              cycles spent in STARTUP after reset (>=1)
//  READ_LATENCY    0              slave read latency in cycles (0..3); 0 = combinational
// PORTS
//  clock           in   1   system clock, all logic on rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  recheck         in   1   1-cycle pulse; honoured only in DONE
//  sysid_address   out  1   word select to sysid slave (0=ID, 1=timestamp)
//  sysid_read      out  1   read strobe to sysid slave
//  sysid_readdata  in   32  sysid slave read data
//  id_value        out  32  captured word 0
//  ts_value        out  32  captured word 1
//  busy            out  1   1 in every state except DONE
//  done            out  1   1 in DONE only
//  id_ok           out  1   id_value == EXPECTED_ID, valid when done=1
//  ts_ok           out  1   timestamp match (or CHECK_TS==0), valid when done=1
// BEHAVIOUR
//  - All outputs are registered. Reset values: state=STARTUP, busy=1, all
//    other outputs 0 (sysid_address, sysid_read, id_value, ts_value, done,
//    id_ok, ts_ok).
//  - States: STARTUP -> RD_ID -> RD_TS -> CHECK -> DONE; DONE -> RD_ID on recheck.
//  - STARTUP: lasts exactly STARTUP_CYCLES cycles, tracked by a down-counter
//    loaded at reset. sysid_read=0.
//  - RD_ID: sysid_read=1, sysid_address=0; lasts READ_LATENCY+1 cycles. At the
//    clock edge that ends the last cycle, id_value <= sysid_readdata.
//  - RD_TS: identical timing with sysid_address=1; the ending edge captures
//    ts_value.
//  - sysid_read/sysid_address change only on state entry and stay constant
//    within a state. sysid_read=0 in STARTUP, CHECK and DONE.
//  - CHECK: lasts 1 cycle. On exit, id_ok <= (id_value==EXPECTED_ID) and
//    ts_ok <= CHECK_TS ? (ts_value==EXPECTED_TS) : 1. done <= 1, busy <= 0.
//  - DONE: holds all outputs until recheck=1. On that edge: done, id_ok and
//    ts_ok clear to 0, busy <= 1, next state is RD_ID (STARTUP is skipped).
//    id_value and ts_value keep their old values until recaptured.
//  - recheck in any state other than DONE is ignored (not queued).
//  - Latency from reset release to done=1 is
//    STARTUP_CYCLES + 2*(READ_LATENCY+1) + 1 cycles. From recheck to done=1
//    it is 2*(READ_LATENCY+1) + 1 cycles.
//  - Reset asserted mid-sequence: immediate return to reset values. A
//    partially captured word is discarded.
//  - Comparisons are full 32-bit equality, with no masking.
//  - The latency counter is 2 bits wide and must not wrap for READ_LATENCY<=3.
// TESTING
//  1. Sysid model (addr?32'h5657_0804:0), defaults, release reset -> read
//     pulses at cycles 4 and 5; done=1 at cycle 7; id_ok=1, ts_ok=1,
//     ts_value=32'h5657_0804.
//  2. Model returns ts 32'h5657_0805 -> done=1, id_ok=1, ts_ok=0. Rerun with
//     CHECK_TS=0 -> ts_ok=1.
//  3. READ_LATENCY=2 with a 2-cycle registered model -> each read state held
//     3 cycles; captures correct; done=1 at cycle 11.
//  4. Pulse recheck in RD_ID (ignored, no extra read), then in DONE -> done
//     drops next cycle, returns 3 cycles later.
//  5. Assert reset_n=0 during RD_TS -> all outputs 0 and busy=1 asynchronously;
//     full sequence reruns after release.
//  6. Model word 0 = 32'h0000_0001 -> id_ok=0, id_value=1, done still asserted.

Source files
------------

// File: rtl/mazesolver_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// mazesolver_soc_sysid_checker
//
// Boot-time consumer of the system-ID Avalon slave. After reset it waits a
// settle period, reads word 0 (system ID) and word 1 (build timestamp), and
// compares both against the values this build expects. The done / id_ok /
// ts_ok flags gate the maze-solver start logic and drive a status LED. A
// recheck pulse while DONE repeats the two reads without a reset.
//
// Ports
//   clock           in   1   system clock, rising edge
//   reset_n         in   1   asynchronous active-low reset
//   recheck         in   1   1-cycle pulse, honoured only in DONE
//   sysid_address   out  1   word select (0 = ID, 1 = timestamp)
//   sysid_read      out  1   read strobe to the sysid slave
//   sysid_readdata  in   32  sysid slave read data
//   id_value        out  32  captured word 0
//   ts_value        out  32  captured word 1
//   busy            out  1   1 in every state except DONE
//   done            out  1   1 in DONE only
//   id_ok           out  1   id_value == EXPECTED_ID, valid when done = 1
//   ts_ok           out  1   timestamp match (or 1 when CHECK_TS == 0)
//   state_dbg       out  3   current FSM state encoding, for debug/checkers
//
// Read handshake: the slave has a fixed read latency and no waitrequest.
// sysid_read and sysid_address are raised on entry to a read state and held
// steady for READ_LATENCY+1 cycles; sysid_readdata is taken on the edge that
// ends the last of those cycles. No other flow control exists.
// -----------------------------------------------------------------------------
module mazesolver_soc_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'h5657_0804,
   parameter bit          CHECK_TS       = 1'b1,
   parameter int          STARTUP_CYCLES = 4,
   parameter int          READ_LATENCY   = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        recheck,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      ST_STARTUP = 3'd0,
      ST_RD_ID   = 3'd1,
      ST_RD_TS   = 3'd2,
      ST_CHECK   = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Startup counter counts STARTUP_CYCLES-1 down to 0, so clog2 of the
   // cycle count is enough bits.
   localparam int          SCW       = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
   localparam logic [SCW-1:0] SC_LOAD = SCW'(STARTUP_CYCLES - 1);
   localparam logic [1:0]  LAT_LOAD  = 2'(READ_LATENCY);

   state_t           state;
   logic [SCW-1:0]   startup_cnt;
   logic [1:0]       lat_cnt;

   assign state_dbg = state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_STARTUP;
         startup_cnt   <= SC_LOAD;
         lat_cnt       <= 2'd0;
         sysid_address <= 1'b0;
         sysid_read    <= 1'b0;
         id_value      <= 32'd0;
         ts_value      <= 32'd0;
         busy          <= 1'b1;
         done          <= 1'b0;
         id_ok         <= 1'b0;
         ts_ok         <= 1'b0;
      end else begin
         case (state)
            ST_STARTUP: begin
               if (startup_cnt == '0) begin
                  state         <= ST_RD_ID;
                  sysid_read    <= 1'b1;
                  sysid_address <= 1'b0;
                  lat_cnt       <= LAT_LOAD;
               end else begin
                  startup_cnt <= startup_cnt - 1'b1;
               end
            end

            ST_RD_ID: begin
               // lat_cnt == 0 marks the final cycle of the read window
               if (lat_cnt == 2'd0) begin
                  id_value      <= sysid_readdata;
                  state         <= ST_RD_TS;
                  sysid_address <= 1'b1;
                  lat_cnt       <= LAT_LOAD;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end

            ST_RD_TS: begin
               if (lat_cnt == 2'd0) begin
                  ts_value      <= sysid_readdata;
                  state         <= ST_CHECK;
                  sysid_read    <= 1'b0;
                  sysid_address <= 1'b0;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end

            ST_CHECK: begin
               id_ok <= (id_value == EXPECTED_ID);
               ts_ok <= CHECK_TS ? (ts_value == EXPECTED_TS) : 1'b1;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_DONE;
            end

            ST_DONE: begin
               // Re-run only the reads; the slave has long since settled.
               if (recheck) begin
                  done          <= 1'b0;
                  id_ok         <= 1'b0;
                  ts_ok         <= 1'b0;
                  busy          <= 1'b1;
                  state         <= ST_RD_ID;
                  sysid_read    <= 1'b1;
                  sysid_address <= 1'b0;
                  lat_cnt       <= LAT_LOAD;
               end
            end

            default: begin
               state <= ST_STARTUP;
               busy  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mazesolver_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_mazesolver_soc_sysid_checker
//
// Two checker instances share clock, reset and recheck:
//   dut_a : defaults (READ_LATENCY 0, timestamp checked), combinational slave
//   dut_b : READ_LATENCY 2, CHECK_TS 0, slave with a 2-stage registered path
// Expected flags, captures and latencies come from the sysid words held in the
// bench and the documented timing formulae.
// -----------------------------------------------------------------------------
module tb_mazesolver_soc_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'h5657_0804;
   localparam int          SC     = 4;
   localparam int          LAT_A  = 0;
   localparam int          LAT_B  = 2;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic recheck = 1'b0;
   always #5 clock = ~clock;

   // ---------------- DUT A ----------------
   logic        a_addr, a_read, a_busy, a_done, a_id_ok, a_ts_ok;
   logic [31:0] a_rdata, a_id_value, a_ts_value;
   logic [2:0]  a_state;
   logic [31:0] a_mem_id, a_mem_ts;

   assign a_rdata = a_addr ? a_mem_ts : a_mem_id;

   mazesolver_soc_sysid_checker dut_a (
      .clock(clock), .reset_n(reset_n), .recheck(recheck),
      .sysid_address(a_addr), .sysid_read(a_read), .sysid_readdata(a_rdata),
      .id_value(a_id_value), .ts_value(a_ts_value), .busy(a_busy),
      .done(a_done), .id_ok(a_id_ok), .ts_ok(a_ts_ok), .state_dbg(a_state)
   );

   // ---------------- DUT B ----------------
   logic        b_addr, b_read, b_busy, b_done, b_id_ok, b_ts_ok;
   logic [31:0] b_rdata, b_id_value, b_ts_value;
   logic [2:0]  b_state;
   logic [31:0] b_mem_id, b_mem_ts;
   logic [31:0] b_pipe1 = 32'd0;
   logic [31:0] b_pipe2 = 32'd0;

   always @(posedge clock) begin
      b_pipe1 <= b_addr ? b_mem_ts : b_mem_id;
      b_pipe2 <= b_pipe1;
   end
   assign b_rdata = b_pipe2;

   mazesolver_soc_sysid_checker #(.CHECK_TS(1'b0), .READ_LATENCY(LAT_B)) dut_b (
      .clock(clock), .reset_n(reset_n), .recheck(recheck),
      .sysid_address(b_addr), .sysid_read(b_read), .sysid_readdata(b_rdata),
      .id_value(b_id_value), .ts_value(b_ts_value), .busy(b_busy),
      .done(b_done), .id_ok(b_id_ok), .ts_ok(b_ts_ok), .state_dbg(b_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] pick(input logic [31:0] exp);
      logic [31:0] v;
      case ($urandom_range(0, 2))
         0:       v = exp;
         1:       v = exp ^ (32'd1 << $urandom_range(0, 31));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Runs edges until both instances report done (bounded). Edge numbering
   // continues from 'start'; a recheck pulse is placed so that edge rc_at+1
   // samples it. Read cycles are counted for the cycle after each edge.
   task automatic wait_done(input int start, input int rc_at,
                            output int da, output int db,
                            output int ra, output int ra_ts, output int rb,
                            output int fra);
      da = -1; db = -1; ra = 0; ra_ts = 0; rb = 0; fra = -1;
      for (int i = start + 1; i <= start + 60 && (da < 0 || db < 0); i++) begin
         step();
         recheck = (i == rc_at);
         if (a_read) begin
            ra++;
            if (a_addr) ra_ts++;
            if (fra < 0) fra = i;
         end
         if (b_read) rb++;
         if (a_done && da < 0) da = i;
         if (b_done && db < 0) db = i;
      end
      recheck = 1'b0;
   endtask

   // Compares the settled DONE outputs with the expectation derived from the
   // words the slaves were holding.
   task automatic check_done_outputs(input string tag);
      chk({tag, ".a_done"},  a_done,     1);
      chk({tag, ".a_busy"},  a_busy,     0);
      chk({tag, ".a_id"},    a_id_value, a_mem_id);
      chk({tag, ".a_ts"},    a_ts_value, a_mem_ts);
      chk({tag, ".a_id_ok"}, a_id_ok,    (a_mem_id == EXP_ID));
      chk({tag, ".a_ts_ok"}, a_ts_ok,    (a_mem_ts == EXP_TS));
      chk({tag, ".a_read"},  a_read,     0);
      chk({tag, ".b_done"},  b_done,     1);
      chk({tag, ".b_busy"},  b_busy,     0);
      chk({tag, ".b_id"},    b_id_value, b_mem_id);
      chk({tag, ".b_ts"},    b_ts_value, b_mem_ts);
      chk({tag, ".b_id_ok"}, b_id_ok,    (b_mem_id == EXP_ID));
      chk({tag, ".b_ts_ok"}, b_ts_ok,    1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, ".a_busy"}, a_busy, 1);
      chk({tag, ".a_flags"}, {a_done, a_id_ok, a_ts_ok, a_read, a_addr}, 0);
      chk({tag, ".a_id"}, a_id_value, 0);
      chk({tag, ".a_ts"}, a_ts_value, 0);
      chk({tag, ".b_busy"}, b_busy, 1);
      chk({tag, ".b_flags"}, {b_done, b_id_ok, b_ts_ok, b_read, b_addr}, 0);
      chk({tag, ".b_id"}, b_id_value, 0);
      chk({tag, ".b_ts"}, b_ts_value, 0);
   endtask

   // Full run from reset release with the latency formula checks.
   task automatic run_from_reset(input string tag, input int rc_at);
      int da, db, ra, ra_ts, rb, fra;
      wait_done(0, rc_at, da, db, ra, ra_ts, rb, fra);
      chk({tag, ".a_first_read"}, fra, SC);
      chk({tag, ".a_done_lat"}, da, SC + 2 * (LAT_A + 1) + 1);
      chk({tag, ".b_done_lat"}, db, SC + 2 * (LAT_B + 1) + 1);
      chk({tag, ".a_reads"}, ra, 2 * (LAT_A + 1));
      chk({tag, ".a_ts_reads"}, ra_ts, LAT_A + 1);
      chk({tag, ".b_reads"}, rb, 2 * (LAT_B + 1));
      repeat (2) step();
      check_done_outputs(tag);
   endtask

   // Recheck from DONE: flags drop on the recheck edge, old captures persist.
   task automatic run_recheck(input string tag);
      int da, db, ra, ra_ts, rb, fra;
      logic [31:0] old_a_id, old_b_ts;
      old_a_id = a_id_value;
      old_b_ts = b_ts_value;
      recheck = 1'b1;
      step();
      recheck = 1'b0;
      chk({tag, ".drop_done"}, {a_done, b_done}, 0);
      chk({tag, ".drop_ok"}, {a_id_ok, a_ts_ok, b_id_ok, b_ts_ok}, 0);
      chk({tag, ".busy"}, {a_busy, b_busy}, 2'b11);
      chk({tag, ".rd_start"}, {a_read, a_addr, b_read, b_addr}, 4'b1010);
      chk({tag, ".keep_a_id"}, a_id_value, old_a_id);
      chk({tag, ".keep_b_ts"}, b_ts_value, old_b_ts);
      wait_done(1, 0, da, db, ra, ra_ts, rb, fra);
      chk({tag, ".a_done_lat"}, da, 2 * (LAT_A + 1) + 2);
      chk({tag, ".b_done_lat"}, db, 2 * (LAT_B + 1) + 2);
      chk({tag, ".a_reads"}, ra, 2 * (LAT_A + 1) - 1);
      chk({tag, ".b_reads"}, rb, 2 * (LAT_B + 1) - 1);
      repeat (2) step();
      check_done_outputs(tag);
   endtask

   initial begin
      // Step 1: matching words, reset values, default timing.
      a_mem_id = EXP_ID; a_mem_ts = EXP_TS;
      b_mem_id = EXP_ID; b_mem_ts = EXP_TS;
      repeat (3) step();
      check_reset_outputs("reset");
      reset_n = 1'b1;
      run_from_reset("boot", -1);

      // DONE holds with no recheck.
      repeat (5) step();
      check_done_outputs("hold");

      // Step 2: timestamp off by one; B ignores the timestamp.
      a_mem_ts = 32'h5657_0805;
      b_mem_ts = 32'h5657_0805;
      run_recheck("ts_off");

      // Step 6: ID word 1 gives id_ok=0 with done still asserted.
      a_mem_id = 32'h0000_0001; b_mem_id = 32'h0000_0001;
      a_mem_ts = EXP_TS;
      run_recheck("id_bad");

      // Step 5: reset in the middle of A's RD_TS, then full rerun.
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      a_mem_id = EXP_ID; b_mem_id = EXP_ID;
      repeat (SC + 1) step();
      chk("mid.a_rd_ts", {a_read, a_addr}, 2'b11);
      #2 reset_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      step();
      reset_n = 1'b1;
      // Step 4: recheck pulsed while both are reading ID is dropped.
      run_from_reset("rerun_rc", SC);

      // Randomized slave contents, repeated rechecks.
      for (int k = 0; k < 8; k++) begin
         a_mem_id = pick(EXP_ID); a_mem_ts = pick(EXP_TS);
         b_mem_id = pick(EXP_ID); b_mem_ts = pick(EXP_TS);
         run_recheck($sformatf("rand%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
